// File: rtl/sc_pkg.sv
// sc_pkg: shared definitions for the switched-capacitor phase sequencer.
//   state_e    : FSM state codes (IDLE..DEAD2, 3 bits wide; codes 6/7 unused)
//   PAT_A      : drive pattern for switch group A {s3,s6} (sample)
//   PAT_B      : drive pattern for switch group B {s2,s4,s5} (hold/transfer)
//   sw_t       : packed switch bundle, SW_ALL_OFF is the break-before-make state
//   sw_decode  : maps a state to its switch pattern
package sc_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        DEAD1  = 3'd2,
        HOLD   = 3'd3,
        CONV   = 3'd4,
        DEAD2  = 3'd5
    } state_e;

    localparam logic [1:0] PAT_A = 2'b11;
    localparam logic [2:0] PAT_B = 3'b111;

    // grp_b = {s2,s4,s5}, grp_a = {s3,s6}
    typedef struct packed {
        logic [2:0] grp_b;
        logic [1:0] grp_a;
    } sw_t;

    localparam sw_t SW_ALL_OFF = '0;

    // Only SAMPLE drives group A and only HOLD/CONV drive group B, so the two
    // groups can never be on together; every other state is all-off.
    function automatic sw_t sw_decode(input state_e st);
        sw_t sw;
        sw = SW_ALL_OFF;
        case (st)
            SAMPLE:     sw.grp_a = PAT_A;
            HOLD, CONV: sw.grp_b = PAT_B;
            default:    sw = SW_ALL_OFF;
        endcase
        return sw;
    endfunction

endpackage

// File: rtl/sc_phase_timer.sv
// sc_phase_timer: loadable down-counter shared by every timed phase.
//   clk, rst_n : clock, asynchronous active-low reset (counter resets to 0)
//   load       : capture load_val (a value of 0 is loaded as 1)
//   load_val   : phase length in cycles
//   done       : high during the last cycle of the loaded interval
// A phase loaded with N therefore lasts exactly N cycles, done marking the Nth.
module sc_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = (load_val == '0) ? W'(1) : load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/sc_phase_sequencer.sv
// sc_phase_sequencer: programmable frame sequencer for the SC ECG front end.
//   clk, rst_n           : clock, asynchronous active-low reset
//   en                   : run enable (checked at frame start/end only)
//   abort                : abandon the current frame through a full DEAD2
//   clr_err              : clears err_timeout (a same-cycle timeout wins)
//   t_samp/t_hold/t_dead : phase lengths, captured on each SAMPLE entry
//   conv_done            : ADC conversion complete (only looked at in CONV)
//   conv_req             : ADC conversion request, high throughout CONV
//   state                : current state code
//   s3,s6 / s2,s4,s5     : switch groups A / B
//   frame_done           : one-cycle pulse after a completed frame
//   frame_cnt            : completed frames, wrapping
//   err_timeout          : sticky CONV timeout flag
//   busy                 : high in every state except IDLE
// All outputs are registered and decoded from the next state so they move on
// the same edge as state.
module sc_phase_sequencer
    import sc_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64,
    parameter int FCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              abort,
    input  logic              clr_err,
    input  logic [CNT_W-1:0]  t_samp,
    input  logic [CNT_W-1:0]  t_hold,
    input  logic [CNT_W-1:0]  t_dead,
    input  logic              conv_done,
    output logic              conv_req,
    output logic [2:0]        state,
    output logic              s2,
    output logic              s4,
    output logic              s5,
    output logic              s3,
    output logic              s6,
    output logic              frame_done,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              err_timeout,
    output logic              busy
);

    // The timer also has to hold the CONV timeout, which may exceed CNT_W.
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam int TW   = (CNT_W > TO_W) ? CNT_W : TO_W;

    state_e             state_q, state_d;
    sw_t                sw_q, sw_d;
    logic               conv_req_q, conv_req_d;
    logic               frame_done_q, frame_done_d;
    logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               aborted_q, aborted_d;
    logic [CNT_W-1:0]   lat_hold_q, lat_hold_d;
    logic [CNT_W-1:0]   lat_dead_q, lat_dead_d;

    logic               tmr_load;
    logic [TW-1:0]      tmr_val;
    logic               tmr_done;
    logic               timeout_set;

    sc_phase_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // Next-state logic. aborted_q remembers that the current DEAD2 came from
    // an abort, which suppresses frame accounting and forces IDLE on exit.
    always_comb begin
        state_d      = state_q;
        aborted_d    = aborted_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        timeout_set  = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && !abort) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (abort) begin
                    state_d   = DEAD2;
                    aborted_d = 1'b1;
                end else if (tmr_done) begin
                    state_d = DEAD1;
                end
            end
            DEAD1: begin
                if (abort) begin
                    state_d   = DEAD2;
                    aborted_d = 1'b1;
                end else if (tmr_done) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (abort) begin
                    state_d   = DEAD2;
                    aborted_d = 1'b1;
                end else if (tmr_done) begin
                    state_d = CONV;
                end
            end
            CONV: begin
                // conv_done is checked before the expiry so a late-but-valid
                // completion never raises a timeout.
                if (abort) begin
                    state_d   = DEAD2;
                    aborted_d = 1'b1;
                end else if (conv_done) begin
                    state_d = DEAD2;
                end else if (tmr_done) begin
                    state_d     = DEAD2;
                    timeout_set = 1'b1;
                end
            end
            DEAD2: begin
                if (tmr_done) begin
                    if (aborted_q) begin
                        state_d   = IDLE;
                        aborted_d = 1'b0;
                    end else begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + FCNT_W'(1);
                        state_d      = en ? SAMPLE : IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                aborted_d = 1'b0;
            end
        endcase
    end

    // Error flag, duration latches, timer reload and output decode.
    // t_samp goes straight into the timer on SAMPLE entry, so only the hold
    // and dead lengths need their own latches for the rest of the frame.
    always_comb begin
        err_d      = err_q;
        lat_hold_d = lat_hold_q;
        lat_dead_d = lat_dead_q;
        tmr_val    = '0;

        if (timeout_set) begin
            err_d = 1'b1;
        end else if (clr_err) begin
            err_d = 1'b0;
        end

        if (state_d == SAMPLE && state_q != SAMPLE) begin
            lat_hold_d = t_hold;
            lat_dead_d = t_dead;
        end

        tmr_load = (state_d != state_q);
        case (state_d)
            SAMPLE:       tmr_val = TW'(t_samp);
            DEAD1, DEAD2: tmr_val = TW'(lat_dead_q);
            HOLD:         tmr_val = TW'(lat_hold_q);
            CONV:         tmr_val = TW'(TIMEOUT);
            default:      tmr_val = '0;
        endcase

        sw_d       = sw_decode(state_d);
        conv_req_d = (state_d == CONV);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sw_q         <= SW_ALL_OFF;
            conv_req_q   <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
            aborted_q    <= 1'b0;
            lat_hold_q   <= CNT_W'(1);
            lat_dead_q   <= CNT_W'(1);
        end else begin
            state_q      <= state_d;
            sw_q         <= sw_d;
            conv_req_q   <= conv_req_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
            aborted_q    <= aborted_d;
            lat_hold_q   <= lat_hold_d;
            lat_dead_q   <= lat_dead_d;
        end
    end

    assign state            = state_q;
    assign {s2, s4, s5}     = sw_q.grp_b;
    assign {s3, s6}         = sw_q.grp_a;
    assign conv_req         = conv_req_q;
    assign frame_done       = frame_done_q;
    assign frame_cnt        = frame_cnt_q;
    assign err_timeout      = err_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_sc_phase_sequencer.sv
// tb_sc_phase_sequencer: directed bench with a cycle-level reference model of
// the frame sequencer plus hand-computed phase-length expectations.
module tb_sc_phase_sequencer;

    localparam int TIMEOUT = 64;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        abort;
    logic        clr_err;
    logic [7:0]  t_samp;
    logic [7:0]  t_hold;
    logic [7:0]  t_dead;
    logic        conv_done = 1'b0;
    logic        conv_req;
    logic [2:0]  state;
    logic        s2, s4, s5, s3, s6;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_timeout;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          fd_seen = 0;
    int          conv_delay = 5;
    bit          chk_en = 1'b0;
    bit          noise = 1'b0;
    bit          prev_a = 1'b0;
    bit          prev_b = 1'b0;

    // Reference model: phase number, cycles already spent in it, frame lengths.
    int          m_ph = 0;
    int          m_el = 0;
    int          m_ds = 1;
    int          m_dh = 1;
    int          m_dd = 1;
    bit          m_ab = 1'b0;
    bit          m_err = 1'b0;
    bit          m_fd = 1'b0;
    logic [15:0] m_fcnt = 16'd0;

    sc_phase_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .abort       (abort),
        .clr_err     (clr_err),
        .t_samp      (t_samp),
        .t_hold      (t_hold),
        .t_dead      (t_dead),
        .conv_done   (conv_done),
        .conv_req    (conv_req),
        .state       (state),
        .s2          (s2),
        .s4          (s4),
        .s5          (s5),
        .s3          (s3),
        .s6          (s6),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .err_timeout (err_timeout),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30) $display("[TB] FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic en_i, input logic [7:0] ts, input logic [7:0] th,
                                 input logic [7:0] td, input int cd);
        en         = en_i;
        t_samp     = ts;
        t_hold     = th;
        t_dead     = td;
        conv_delay = cd;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic waitState(input logic [2:0] code, input string nm);
        int n;
        n = 0;
        while (state !== code && n < 400) begin
            step();
            n++;
        end
        checkOutput(nm, {29'd0, state}, {29'd0, code});
    endtask

    task automatic phaseLen(input logic [2:0] code, output int len);
        len = 0;
        while (state === code && len < 400) begin
            step();
            len++;
        end
    endtask

    function automatic int clamp1(input logic [7:0] v);
        return (v == 8'd0) ? 1 : int'(v);
    endfunction

    function automatic logic [31:0] outVec();
        return {4'd0, state, s2, s4, s5, s3, s6, conv_req, frame_done, busy, err_timeout, frame_cnt};
    endfunction

    function automatic logic [31:0] expVec();
        logic a, b;
        a = (m_ph == 1);
        b = (m_ph == 3) || (m_ph == 4);
        return {4'd0, 3'(m_ph), b, b, b, a, a, (m_ph == 4), m_fd, (m_ph != 0), m_err, m_fcnt};
    endfunction

    // One model step per clock: decide whether the phase just finished has
    // run its length (counting cycles upward) and apply the frame rules.
    task automatic modelStep();
        int  inph;
        int  nph;
        bit  tset;
        inph = m_el + 1;
        nph  = m_ph;
        tset = 1'b0;
        m_fd = 1'b0;
        case (m_ph)
            0: if (en && !abort) nph = 1;
            1: if (abort) begin nph = 5; m_ab = 1'b1; end else if (inph >= m_ds) nph = 2;
            2: if (abort) begin nph = 5; m_ab = 1'b1; end else if (inph >= m_dd) nph = 3;
            3: if (abort) begin nph = 5; m_ab = 1'b1; end else if (inph >= m_dh) nph = 4;
            4: begin
                if (abort) begin nph = 5; m_ab = 1'b1; end
                else if (conv_done) nph = 5;
                else if (inph >= TIMEOUT) begin nph = 5; tset = 1'b1; end
            end
            5: begin
                if (inph >= m_dd) begin
                    if (m_ab) begin
                        nph  = 0;
                        m_ab = 1'b0;
                    end else begin
                        m_fd   = 1'b1;
                        m_fcnt = m_fcnt + 16'd1;
                        nph    = en ? 1 : 0;
                    end
                end
            end
            default: nph = 0;
        endcase
        if (tset) m_err = 1'b1;
        else if (clr_err) m_err = 1'b0;
        if (nph == 1 && m_ph != 1) begin
            m_ds = clamp1(t_samp);
            m_dh = clamp1(t_hold);
            m_dd = clamp1(t_dead);
        end
        m_el = (nph == m_ph) ? m_el + 1 : 0;
        m_ph = nph;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_ph = 0; m_el = 0; m_ds = 1; m_dh = 1; m_dd = 1;
            m_ab = 1'b0; m_err = 1'b0; m_fd = 1'b0; m_fcnt = 16'd0;
        end else begin
            modelStep();
        end
    end

    // ADC stand-in: completes conv_delay cycles into CONV (0 = never), and
    // optionally toggles conv_done randomly outside CONV.
    initial forever begin
        @(posedge clk);
        #1;
        if (m_ph == 4) conv_done = (m_el == conv_delay - 1);
        else if (noise) conv_done = 1'($urandom_range(0, 1));
        else conv_done = 1'b0;
    end

    initial forever begin
        logic a_now, b_now;
        @(posedge clk);
        #2;
        if (chk_en) begin
            checkOutput("cycle", outVec(), expVec());
            a_now = s3 | s6;
            b_now = s2 | s4 | s5;
            checkOutput("no_overlap", {31'd0, a_now & b_now}, 32'd0);
            checkOutput("dead_time", {31'd0, (a_now && prev_b) || (b_now && prev_a)}, 32'd0);
            prev_a = a_now;
            prev_b = b_now;
            if (frame_done === 1'b1) fd_seen++;
        end
    end

    initial begin
        int len;
        int n;
        int fd0;
        logic [15:0] fc0;
        logic [15:0] target;

        rst_n = 1'b1;
        abort = 1'b0;
        clr_err = 1'b0;
        applyStimulus(1'b0, 8'd1, 8'd1, 8'd1, 5);
        #1 rst_n = 1'b0;
        repeat (3) step();
        checkOutput("reset_outputs", outVec(), 32'd0);
        chk_en = 1'b1;
        rst_n = 1'b1;

        // Basic frame
        applyStimulus(1'b1, 8'd4, 8'd3, 8'd2, 5);
        waitState(3'd1, "basic_start");
        phaseLen(3'd1, len); checkOutput("basic_samp_len", len, 4);
        phaseLen(3'd2, len); checkOutput("basic_dead1_len", len, 2);
        phaseLen(3'd3, len); checkOutput("basic_hold_len", len, 3);
        phaseLen(3'd4, len); checkOutput("basic_conv_len", len, 5);
        phaseLen(3'd5, len); checkOutput("basic_dead2_len", len, 2);
        checkOutput("basic_next_samp", {29'd0, state}, 32'd1);
        checkOutput("basic_frame_done", {31'd0, frame_done}, 32'd1);
        checkOutput("basic_frame_cnt", {16'd0, frame_cnt}, 32'd1);
        checkOutput("model_fcnt", {16'd0, m_fcnt}, 32'd1);

        // Zero durations behave as one cycle
        applyStimulus(1'b1, 8'd0, 8'd0, 8'd0, 1);
        waitState(3'd5, "zero_prev_dead2");
        waitState(3'd1, "zero_start");
        phaseLen(3'd1, len); checkOutput("zero_samp_len", len, 1);
        phaseLen(3'd2, len); checkOutput("zero_dead1_len", len, 1);
        phaseLen(3'd3, len); checkOutput("zero_hold_len", len, 1);
        phaseLen(3'd4, len); checkOutput("zero_conv_len", len, 1);
        phaseLen(3'd5, len); checkOutput("zero_dead2_len", len, 1);

        // Random durations over 500 frames
        noise = 1'b1;
        target = m_fcnt + 16'd500;
        n = 0;
        while (m_fcnt != target && n < 60000) begin
            t_samp  = 8'($urandom_range(0, 15));
            t_hold  = 8'($urandom_range(0, 15));
            t_dead  = 8'($urandom_range(0, 15));
            clr_err = ($urandom_range(0, 7) == 0);
            if (m_ph != 4) conv_delay = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, 10));
            step();
            n++;
        end
        checkOutput("rand_frames", {16'd0, frame_cnt}, {16'd0, target});
        noise = 1'b0;
        clr_err = 1'b0;
        applyStimulus(1'b0, 8'd1, 8'd1, 8'd1, 1);
        waitState(3'd0, "rand_idle");
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        // Abort in HOLD
        applyStimulus(1'b1, 8'd4, 8'd5, 8'd3, 3);
        waitState(3'd3, "abort_hold");
        step();
        fc0 = m_fcnt;
        fd0 = fd_seen;
        abort = 1'b1;
        step();
        abort = 1'b0;
        checkOutput("abort_state", {29'd0, state}, 32'd5);
        checkOutput("abort_switches", {27'd0, s2, s4, s5, s3, s6}, 32'd0);
        phaseLen(3'd5, len); checkOutput("abort_dead2_len", len, 3);
        checkOutput("abort_idle", {29'd0, state}, 32'd0);
        checkOutput("abort_fcnt", {16'd0, frame_cnt}, {16'd0, fc0});
        checkOutput("abort_no_fdone", fd_seen, fd0);

        // Abort held in IDLE blocks start
        abort = 1'b1;
        repeat (5) step();
        checkOutput("abort_idle_block", {28'd0, state, busy}, 32'd0);
        abort = 1'b0;
        waitState(3'd1, "restart_after_abort");

        // CONV timeout
        applyStimulus(1'b1, 8'd2, 8'd2, 8'd1, 0);
        waitState(3'd4, "timeout_conv");
        len = 0;
        while (conv_req === 1'b1 && len < 200) begin
            step();
            len++;
        end
        checkOutput("timeout_req_len", len, 64);
        checkOutput("timeout_err", {31'd0, err_timeout}, 32'd1);
        checkOutput("timeout_dead2", {29'd0, state}, 32'd5);
        en = 1'b0;
        waitState(3'd0, "timeout_idle");
        checkOutput("timeout_sticky", {31'd0, err_timeout}, 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checkOutput("timeout_cleared", {31'd0, err_timeout}, 32'd0);

        // en drop in SAMPLE
        applyStimulus(1'b1, 8'd3, 8'd2, 8'd1, 2);
        waitState(3'd1, "endrop_samp");
        en = 1'b0;
        fc0 = m_fcnt;
        fd0 = fd_seen;
        waitState(3'd0, "endrop_idle");
        checkOutput("endrop_fcnt", {16'd0, frame_cnt}, {16'd0, fc0 + 16'd1});
        checkOutput("endrop_fdone", fd_seen, fd0 + 1);
        checkOutput("endrop_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-CONV
        applyStimulus(1'b1, 8'd2, 8'd2, 8'd1, 0);
        waitState(3'd4, "areset_conv");
        repeat (3) step();
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("areset_outputs", outVec(), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'd2, 8'd2, 8'd1, 2);
        waitState(3'd1, "areset_restart");
        en = 1'b0;
        waitState(3'd0, "areset_done");
        checkOutput("areset_fcnt", {16'd0, frame_cnt}, 32'd1);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sc_phase_sequencer.md
Name: sc_phase_sequencer

Overview:
- Frame sequencer for the switched-capacitor ECG front end.
- Drives switch groups A (s3,s6: sample) and B (s2,s4,s5: hold/transfer) with guaranteed break-before-make dead time.
- Runs the ADC conversion request/acknowledge handshake once per frame.
- Sits between the front-end switch array and the ADC sample path, replacing a fixed-pattern switch controller with a programmable, restartable one.

Parameters:
- CNT_W, 8, width of the phase-duration inputs and internal phase counter
- TIMEOUT, 64, maximum cycles in CONV waiting for conv_done before error
- FCNT_W, 16, width of the frame counter

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; level-sensitive
- abort  in  1  synchronous abort request (level)
- clr_err  in  1  clears err_timeout
- t_samp  in  CNT_W  SAMPLE phase length in cycles
- t_hold  in  CNT_W  HOLD phase length in cycles
- t_dead  in  CNT_W  dead-time length in cycles
- conv_done  in  1  ADC conversion complete
- conv_req  out  1  ADC conversion request
- state  out  3  current FSM state code
- s2,s4,s5  out  1 each  switch group B
- s3,s6  out  1 each  switch group A
- frame_done  out  1  one-cycle pulse at frame end
- frame_cnt  out  FCNT_W  completed frames, wraps
- err_timeout  out  1  sticky conversion-timeout flag
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All switches, conv_req, frame_done, err_timeout and busy = 0.
  - frame_cnt=0; phase counter=0; latched durations=1.
- State codes: IDLE=0, SAMPLE=1, DEAD1=2, HOLD=3, CONV=4, DEAD2=5. Codes 6 and 7 are illegal and recover to IDLE on the next clock.
- Outputs are registered and decoded from the next state, so they change on the same edge as state.
  - SAMPLE: A=1, B=0.
  - HOLD and CONV: B=1, A=0.
  - IDLE, DEAD1, DEAD2: all switches 0.
- A and B are never high in the same cycle. Every A↔B change passes through at least one all-off cycle.
- Duration latching: t_samp, t_hold and t_dead are captured on each entry to SAMPLE and held for the whole frame. A latched value of 0 is treated as 1.
- Transitions:
  - IDLE→SAMPLE when en=1 and abort=0.
  - SAMPLE lasts t_samp cycles, then →DEAD1.
  - DEAD1 lasts t_dead cycles, then →HOLD.
  - HOLD lasts t_hold cycles, then →CONV.
  - CONV: conv_req=1 until conv_done is sampled high, then →DEAD2. conv_req drops on that same edge.
  - CONV timeout: after TIMEOUT cycles without conv_done, set err_timeout and →DEAD2.
  - DEAD2 lasts t_dead cycles. On exit: frame_done pulses for 1 cycle, frame_cnt increments (wrapping at 2^FCNT_W), then →SAMPLE if en=1, else →IDLE.
- en deassert mid-frame: the current frame completes normally, then the FSM goes to IDLE.
- abort=1 in SAMPLE, DEAD1, HOLD or CONV:
  - Next state is DEAD2 and all switches go off at once.
  - conv_req drops.
  - DEAD2 runs its full t_dead, then goes to IDLE regardless of en.
  - No frame_done pulse and no frame_cnt increment.
- abort held in IDLE blocks start.
- conv_done is ignored outside CONV. If it arrives in the same cycle as the timeout expiry, conv_done wins and err_timeout is not set.
- err_timeout is cleared only by clr_err or rst_n. If clr_err and a new timeout occur in the same cycle, set wins.
- Reset asserted mid-operation forces all outputs to their reset values immediately (asynchronously).

Decomposition:
- Shared package sc_pkg holds:
  - the state enum/localparams (IDLE…DEAD2, width 3);
  - the switch-pattern constants PAT_A=2'b11 and PAT_B=3'b111;
  - the all-off constant.
- One sub-module, sc_phase_timer: loadable down-counter with a zero-as-one clamp and a done flag, reused for all timed phases and the CONV timeout.

Test Plan:
- Basic frame: reset, en=1, t_samp=4, t_dead=2, t_hold=3, conv_done 5 cycles after conv_req rises. Required:
  - SAMPLE 4 cycles, DEAD1 2, HOLD 3, CONV 5, DEAD2 2;
  - frame_done pulse; frame_cnt=1; next SAMPLE immediately.
- Non-overlap check: random durations 0–15 over 500 frames. Required:
  - (s3|s6)&(s2|s4|s5) is never 1;
  - every A/B change has at least 1 all-off cycle;
  - a 0 duration behaves as 1.
- Timeout: conv_done tied 0, TIMEOUT=64. Required:
  - conv_req high exactly 64 cycles, err_timeout=1, frame continues;
  - clr_err pulse → err_timeout=0.
- Abort in HOLD: abort=1 for 1 cycle. Required:
  - next cycle all switches 0, state=5;
  - after t_dead cycles state=0;
  - frame_cnt unchanged; no frame_done.
- en drop in SAMPLE: required that the frame completes through DEAD2, frame_cnt increments, then IDLE with busy=0.
- Async reset mid-CONV: rst_n low between edges. Required:
  - outputs zero immediately;
  - frame_cnt=0;
  - restart works after release.
